// File: rtl/mist_io_spi_master.sv
// SPI mode-0 initiator feeding user_io: one command byte plus 0..4 payload bytes per
// transaction, with SS held low throughout and a fixed setup/hold/gap around the burst.
module mist_io_spi_master #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk_sys,
    input  logic        res_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_code,
    input  logic [2:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        done,
    output logic [31:0] rx_data,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_ss_n,
    input  logic        spi_miso,
    output logic [2:0]  dbg_state
);

    // Request handshake: a transaction is taken on any clk_sys edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high exactly while IDLE and cmd_* are not
    // looked at again after that edge.
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic [5:0]  nbits_q, nbits_d;
    logic [39:0] sh_q, sh_d;
    logic [31:0] rx_q, rx_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        ss_n_q, ss_n_d;
    logic        done_q, done_d;

    logic        tick;
    logic [2:0]  len_eff;
    logic [5:0]  bit_nxt;

    assign tick    = (div_q == DIV_LAST);
    assign len_eff = (cmd_len > 3'd4) ? 3'd4 : cmd_len;
    assign bit_nxt = bit_q + 6'd1;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        nbits_d = nbits_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        ss_n_d  = ss_n_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // Payload goes out LSB byte first, each byte MSB first; unused tail bytes are never shifted out.
                    sh_d    = {cmd_code, cmd_data[7:0], cmd_data[15:8], cmd_data[23:16], cmd_data[31:24]};
                    nbits_d = {len_eff, 3'b000} + 6'd8;
                    mosi_d  = cmd_code[7];
                    ss_n_d  = 1'b0;
                    sck_d   = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    rx_d    = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    div_d   = '0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[30:0], spi_miso};
                    end else begin
                        sck_d = 1'b0;
                        bit_d = bit_nxt;
                        if (bit_nxt == nbits_q) begin
                            state_d = HOLD;
                        end else begin
                            sh_d   = {sh_q[38:0], 1'b0};
                            mosi_d = sh_q[38];
                        end
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            HOLD: begin
                if (tick) begin
                    div_d   = '0;
                    ss_n_d  = 1'b1;
                    state_d = GAP;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            GAP: begin
                if (tick) begin
                    div_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            nbits_q <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            nbits_q <= nbits_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            ss_n_q  <= ss_n_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign done      = done_q;
    assign rx_data   = rx_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = mosi_q;
    assign spi_ss_n  = ss_n_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mist_io_spi_master.sv
// Randomized bench for mist_io_spi_master: a wire monitor collects SCK-rise bits, SS and done
// timing, and each transaction is compared with the bit stream and timing derived from its request.
module tb_mist_io_spi_master;
    localparam int CD = 2;

    logic        clk_sys = 1'b0;
    logic        res_n   = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_code = '0;
    logic [2:0]  cmd_len  = '0;
    logic [31:0] cmd_data = '0;
    logic        done;
    logic [31:0] rx_data;
    logic        spi_sck, spi_mosi, spi_ss_n, spi_miso;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    // monitor state
    int   cyc = 0;
    int   ss_low_cnt = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   ss_rise_cyc = 0;
    int   last_gap = 0;
    logic [31:0] rx_at_done = '0;
    logic sck_prev = 1'b0;
    logic ss_prev  = 1'b1;
    logic lb = 1'b0;
    logic miso_r = 1'b0;
    logic mosi_seen[$];
    logic miso_seen[$];
    logic [39:0] exp_q[$];

    mist_io_spi_master #(.CLK_DIV(CD)) dut (
        .clk_sys  (clk_sys),
        .res_n    (res_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_code (cmd_code),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .done     (done),
        .rx_data  (rx_data),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_ss_n (spi_ss_n),
        .spi_miso (spi_miso),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk_sys = ~clk_sys;

    assign spi_miso = lb ? spi_mosi : miso_r;

    // wire monitor, sampled on the falling clk_sys edge
    always @(negedge clk_sys) begin
        cyc = cyc + 1;
        if (!spi_ss_n) ss_low_cnt = ss_low_cnt + 1;
        if (spi_ss_n && !ss_prev) ss_rise_cyc = cyc;
        if (!spi_ss_n && ss_prev) last_gap = cyc - ss_rise_cyc;
        ss_prev = spi_ss_n;
        if (spi_sck && !sck_prev) begin
            mosi_seen.push_back(spi_mosi);
            miso_seen.push_back(spi_miso);
        end
        sck_prev = spi_sck;
        if (done) begin
            done_cnt   = done_cnt + 1;
            done_cyc   = cyc;
            rx_at_done = rx_data;
        end
        // MISO only changes while SCK is high, so it is stable at the next rise
        if (spi_sck) miso_r = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_len(input logic [2:0] len);
        return (len > 3'd4) ? 4 : int'(len);
    endfunction

    // Expected wire word, left-aligned in 40 bits: command, then payload bytes low to high.
    function automatic logic [39:0] wire_word(input logic [7:0] code, input logic [2:0] len,
                                              input logic [31:0] data);
        logic [39:0] w;
        logic [7:0]  b;
        w = '0;
        w[39:32] = code;
        for (int i = 0; i < eff_len(len); i++) begin
            b = data[8*i +: 8];
            w[31 - 8*i -: 8] = b;
        end
        return w;
    endfunction

    task automatic clear_mon();
        mosi_seen.delete();
        miso_seen.delete();
        ss_low_cnt = 0;
        done_cnt   = 0;
    endtask

    task automatic wait_ready(output int acc_cyc);
        int guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk_sys); #1;
            guard++;
        end
        check("ready_wait", {63'b0, cmd_ready}, 64'd1);
        acc_cyc = cyc;
    endtask

    task automatic wait_done(input int count);
        int guard = 0;
        while (done_cnt < count && guard < 2000) begin
            @(negedge clk_sys); #1;
            guard++;
        end
        check("done_wait", 64'(done_cnt >= count), 64'd1);
    endtask

    task automatic run_txn(input logic [7:0] code, input logic [2:0] len, input logic [31:0] data,
                           input logic loop, output logic [31:0] rx_out);
        int a_cyc, nbits;
        logic [39:0] got_w, exp_w;
        logic [31:0] exp_rx;
        @(negedge clk_sys); #1;
        lb = loop;
        clear_mon();
        exp_q.push_back(wire_word(code, len, data));
        cmd_code  = code;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        wait_ready(a_cyc);
        @(posedge clk_sys); #1;
        cmd_valid = 1'b0;
        cmd_code  = 8'($urandom);
        cmd_len   = 3'($urandom);
        cmd_data  = $urandom;
        wait_done(1);
        repeat (2*CD + 2) @(negedge clk_sys);
        #1;
        nbits = 8 * (eff_len(len) + 1);
        exp_w = exp_q.pop_front();
        got_w = '0;
        foreach (mosi_seen[i]) if (i < 40) got_w[39 - i] = mosi_seen[i];
        exp_rx = '0;
        foreach (miso_seen[i]) exp_rx = {exp_rx[30:0], miso_seen[i]};
        check("sck_rises", 64'(mosi_seen.size()), 64'(nbits));
        check("mosi_bits", {24'b0, got_w}, {24'b0, exp_w});
        check("ss_low_cycles", 64'(ss_low_cnt), 64'(CD * (2 + 2*nbits)));
        check("done_count", 64'(done_cnt), 64'd1);
        check("accept_to_done", 64'(done_cyc - a_cyc), 64'(CD * (3 + 2*nbits) + 1));
        check("rx_data", {32'b0, rx_at_done}, {32'b0, exp_rx});
        rx_out = rx_at_done;
        lb = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx;
        int a1, a2, guard;
        logic [7:0] code;

        // reset state
        repeat (3) @(negedge clk_sys);
        check("rst_ss_n", {63'b0, spi_ss_n}, 64'd1);
        check("rst_sck", {63'b0, spi_sck}, 64'd0);
        check("rst_mosi", {63'b0, spi_mosi}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_rx", {32'b0, rx_data}, 64'd0);
        res_n = 1'b1;
        @(negedge clk_sys); #1;
        check("rst_ready", {63'b0, cmd_ready}, 64'd1);

        // joystick 0, one payload byte
        run_txn(8'h02, 3'd1, 32'h0000_0010, 1'b0, rx);
        // status32, full payload
        run_txn(8'h1E, 3'd4, 32'h0000_0021, 1'b0, rx);
        // loopback: MISO echoes MOSI
        run_txn(8'h03, 3'd1, 32'h0000_005A, 1'b1, rx);
        check("loopback_rx", {48'b0, rx[15:0]}, 64'h035A);
        // oversized length behaves as four bytes
        run_txn(8'h04, 3'd7, 32'h1122_3344, 1'b0, rx);

        // reset in the middle of a transfer
        @(negedge clk_sys); #1;
        clear_mon();
        cmd_code = 8'h1E; cmd_len = 3'd4; cmd_data = 32'hDEAD_BEEF; cmd_valid = 1'b1;
        wait_ready(a1);
        @(posedge clk_sys); #1;
        cmd_valid = 1'b0;
        guard = 0;
        while (mosi_seen.size() < 5 && guard < 500) begin
            @(negedge clk_sys); #1;
            guard++;
        end
        check("reached_bit5", 64'(mosi_seen.size()), 64'd5);
        res_n = 1'b0;
        #1;
        check("async_ss_n", {63'b0, spi_ss_n}, 64'd1);
        check("async_sck", {63'b0, spi_sck}, 64'd0);
        repeat (3) @(negedge clk_sys);
        res_n = 1'b1;
        repeat (40) @(negedge clk_sys);
        #1;
        check("no_done_after_reset", 64'(done_cnt), 64'd0);
        run_txn(8'h01, 3'd2, 32'h0000_A55A, 1'b0, rx);

        // back-to-back requests with cmd_valid held high
        @(negedge clk_sys); #1;
        clear_mon();
        code = 8'($urandom);
        cmd_code = code; cmd_len = 3'd0; cmd_data = $urandom; cmd_valid = 1'b1;
        wait_ready(a1);
        wait_done(1);
        check("ready_in_done_cycle", {63'b0, cmd_ready}, 64'd1);
        a2 = cyc;
        check("first_latency", 64'(a2 - a1), 64'(CD * (3 + 16) + 1));
        @(posedge clk_sys); #1;
        cmd_valid = 1'b0;
        wait_done(2);
        check("second_latency", 64'(done_cyc - a2), 64'(CD * (3 + 16) + 1));
        // SS high for the GAP cycles plus the done/accept cycle
        check("ss_gap", 64'(last_gap), 64'(CD + 1));
        repeat (10) @(negedge clk_sys);
        #1;
        check("two_dones", 64'(done_cnt), 64'd2);

        // random traffic, random MISO or loopback
        for (int t = 0; t < 10; t++) begin
            run_txn(8'($urandom), 3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)), rx);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
